// File: rtl/memoram_dp.sv
// Dual-port synchronous RAM (port A read/write, port B read-only) with registered outputs
// and a post-reset clear sequencer. Optional parity storage/checking via MEMORAM_DP_PARITY_EN.
module memoram_dp #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 6,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_a,
  input  logic              rden_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              rden_b,
  output logic [DATA_W-1:0] q_b,
`ifdef MEMORAM_DP_PARITY_EN
  input  logic              perr_inject,
  output logic              perr_a,
  output logic              perr_b,
`endif
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEMORAM_DP_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly.
  state_t          state;
  state_t          state_next;
  logic [ADDR_W:0] clr_addr;
  logic [ADDR_W:0] clr_addr_next;
  logic            clr_last;
  logic            active;
  logic            clr_en;
  logic            wr_en;
  logic            fwd_a;
  logic            fwd_b;
  logic [MEM_W-1:0] wr_word;
  logic [MEM_W-1:0] rd_word_a;
  logic [MEM_W-1:0] rd_word_b;
  logic [MEM_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  assign clr_last = (clr_addr == CLR_END);

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    case (state)
      ST_CLEAR: begin
        if (clr_last) begin
          state_next    = ST_IDLE;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr + 1'b1;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        clr_addr_next = clr_addr;
      end
    endcase
  end

  assign busy   = (state == ST_CLEAR);
  assign active = !reset && !busy;
  assign clr_en = !reset && busy;
  assign wr_en  = active && wren_a;

`ifdef MEMORAM_DP_PARITY_EN
  // Stored bit makes the word even parity; inject flips it to model a corrupted cell.
  assign wr_word = {(^data_a) ^ perr_inject, data_a};
`else
  assign wr_word = data_a;
`endif

  always_ff @(posedge clock) begin
    if (clr_en) begin
      mem[clr_addr[ADDR_W-1:0]] <= '0;
    end else if (wr_en) begin
      mem[address_a] <= wr_word;
    end
  end

  assign rd_word_a = mem[address_a];
  assign rd_word_b = mem[address_b];
  // Forwarding only matters when the same-cycle write hits the word being read.
  assign fwd_a = (RDW_MODE != 0) && wren_a;
  assign fwd_b = (RDW_MODE != 0) && wren_a && (address_b == address_a);

  always_ff @(posedge clock) begin
    if (reset || busy) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (rden_a) q_a <= fwd_a ? data_a : rd_word_a[DATA_W-1:0];
      if (rden_b) q_b <= fwd_b ? data_a : rd_word_b[DATA_W-1:0];
    end
  end

`ifdef MEMORAM_DP_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset || busy) begin
      perr_a <= 1'b0;
      perr_b <= 1'b0;
    end else begin
      if (rden_a) perr_a <= fwd_a ? 1'b0 : (rd_word_a[DATA_W] != ^rd_word_a[DATA_W-1:0]);
      if (rden_b) perr_b <= fwd_b ? 1'b0 : (rd_word_b[DATA_W] != ^rd_word_b[DATA_W-1:0]);
    end
  end
`endif

endmodule

// File: tb/tb_memoram_dp.sv
// Bench for memoram_dp: two instances (old-data/clear-on-reset and new-data/retain) share
// stimulus and are checked every cycle against an array-based reference model.
module tb_memoram_dp;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset0 = 1'b0;
  logic              reset1 = 1'b0;
  logic [ADDR_W-1:0] address_a = '0;
  logic [DATA_W-1:0] data_a = '0;
  logic              wren_a = 1'b0;
  logic              rden_a = 1'b0;
  logic [ADDR_W-1:0] address_b = '0;
  logic              rden_b = 1'b0;
  logic              perr_inject = 1'b0;

  logic [DATA_W-1:0] q_a0, q_b0, q_a1, q_b1;
  logic              busy0, busy1;
`ifdef MEMORAM_DP_PARITY_EN
  logic              perr_a0, perr_b0, perr_a1, perr_b1;
`endif

  memoram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clock(clock), .reset(reset0),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a0),
    .address_b(address_b), .rden_b(rden_b), .q_b(q_b0),
`ifdef MEMORAM_DP_PARITY_EN
    .perr_inject(perr_inject), .perr_a(perr_a0), .perr_b(perr_b0),
`endif
    .busy(busy0)
  );

  memoram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(1), .CLEAR_ON_RESET(0)) u_dut1 (
    .clock(clock), .reset(reset1),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a1),
    .address_b(address_b), .rden_b(rden_b), .q_b(q_b1),
`ifdef MEMORAM_DP_PARITY_EN
    .perr_inject(perr_inject), .perr_a(perr_a1), .perr_b(perr_b1),
`endif
    .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance, memory array plus a countdown of remaining clear cycles.
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  logic              m_par [2][DEPTH];
  int                m_clear_left [2] = '{0, 0};
  logic [DATA_W-1:0] m_q_a [2] = '{16'h0, 16'h0};
  logic [DATA_W-1:0] m_q_b [2] = '{16'h0, 16'h0};
  logic              m_pe_a [2] = '{1'b0, 1'b0};
  logic              m_pe_b [2] = '{1'b0, 1'b0};

  function automatic bit new_data_mode(input int i);
    return (i == 1);
  endfunction

  function automatic bit clears_on_reset(input int i);
    return (i == 0);
  endfunction

  task automatic model_edge();
    logic rst;
    logic [DATA_W-1:0] old_a, old_b;
    logic par_a, par_b;
    for (int i = 0; i < 2; i++) begin
      rst = (i == 0) ? reset0 : reset1;
      if (rst) begin
        m_q_a[i] = '0; m_q_b[i] = '0; m_pe_a[i] = 1'b0; m_pe_b[i] = 1'b0;
        m_clear_left[i] = clears_on_reset(i) ? DEPTH : 0;
      end else if (m_clear_left[i] > 0) begin
        m_mem[i][DEPTH - m_clear_left[i]] = '0;
        m_par[i][DEPTH - m_clear_left[i]] = 1'b0;
        m_q_a[i] = '0; m_q_b[i] = '0; m_pe_a[i] = 1'b0; m_pe_b[i] = 1'b0;
        m_clear_left[i]--;
      end else begin
        old_a = m_mem[i][address_a]; par_a = m_par[i][address_a];
        old_b = m_mem[i][address_b]; par_b = m_par[i][address_b];
        if (rden_a) begin
          if (new_data_mode(i) && wren_a) begin
            m_q_a[i] = data_a; m_pe_a[i] = 1'b0;
          end else begin
            m_q_a[i] = old_a; m_pe_a[i] = (par_a != ^old_a);
          end
        end
        if (rden_b) begin
          if (new_data_mode(i) && wren_a && address_b == address_a) begin
            m_q_b[i] = data_a; m_pe_b[i] = 1'b0;
          end else begin
            m_q_b[i] = old_b; m_pe_b[i] = (par_b != ^old_b);
          end
        end
        if (wren_a) begin
          m_mem[i][address_a] = data_a;
          m_par[i][address_a] = (^data_a) ^ perr_inject;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("d0_busy", 32'(busy0), 32'(m_clear_left[0] > 0));
    check("d1_busy", 32'(busy1), 32'(m_clear_left[1] > 0));
    check("d0_q_a", 32'(q_a0), 32'(m_q_a[0]));
    check("d0_q_b", 32'(q_b0), 32'(m_q_b[0]));
    check("d1_q_a", 32'(q_a1), 32'(m_q_a[1]));
    check("d1_q_b", 32'(q_b1), 32'(m_q_b[1]));
`ifdef MEMORAM_DP_PARITY_EN
    check("d0_perr_a", 32'(perr_a0), 32'(m_pe_a[0]));
    check("d0_perr_b", 32'(perr_b0), 32'(m_pe_b[0]));
    check("d1_perr_a", 32'(perr_a1), 32'(m_pe_a[1]));
    check("d1_perr_b", 32'(perr_b1), 32'(m_pe_b[1]));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic op(input logic wa, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                    input logic ra, input logic [ADDR_W-1:0] ab, input logic rb);
    wren_a = wa; address_a = aa; data_a = da; rden_a = ra; address_b = ab; rden_b = rb;
    step();
  endtask

  int busy_cycles;

  initial begin
    // Reset both; dut0 clears for 64 cycles while dut1 accepts an initial fill.
    reset0 = 1'b1; reset1 = 1'b1;
    op(0, 0, 0, 0, 0, 0);
    reset0 = 1'b0; reset1 = 1'b0;
    busy_cycles = busy0 ? 1 : 0;
    for (int k = 0; k < DEPTH; k++) begin
      op(1, ADDR_W'(k), DATA_W'($urandom), 0, 0, 0);
      if (busy0) busy_cycles++;
    end
    check("busy_len_first", 32'(busy_cycles), 32'd64);
    for (int k = 0; k < DEPTH; k++) begin
      op(0, 0, 0, 1, ADDR_W'(k), 1);
      check("cleared_b", 32'(q_b0), 32'h0);
      address_a = ADDR_W'(DEPTH - 1 - k);
      op(0, ADDR_W'(DEPTH - 1 - k), 0, 1, 0, 0);
      check("cleared_a", 32'(q_a0), 32'h0);
    end

    // Independent dual-port reads.
    op(1, 5, 16'hAAAA, 0, 0, 0);
    op(1, 10, 16'h1234, 0, 0, 0);
    op(1, 20, 16'hFFFF, 0, 0, 0);
    op(0, 10, 0, 1, 20, 1);
    check("dual_q_a", 32'(q_a0), 32'h1234);
    check("dual_q_b", 32'(q_b0), 32'hFFFF);

    // Read-during-write through port B.
    op(1, 7, 16'h1111, 0, 0, 0);
    op(1, 7, 16'h2222, 0, 7, 1);
    check("rdw_old", 32'(q_b0), 32'h1111);
    check("rdw_new", 32'(q_b1), 32'h2222);
    op(0, 7, 0, 1, 7, 1);
    check("after_rdw_d0", 32'(q_a0), 32'h2222);
    check("after_rdw_d1", 32'(q_a1), 32'h2222);

    // Hold on rden low, and retention across reset without clear.
    op(0, 5, 0, 1, 0, 0);
    check("hold_pre", 32'(q_a0), 32'hAAAA);
    op(0, 10, 0, 0, 0, 0);
    check("hold_q_a", 32'(q_a0), 32'hAAAA);
    reset1 = 1'b1;
    op(0, 0, 0, 0, 0, 0);
    reset1 = 1'b0;
    op(0, 5, 0, 1, 0, 0);
    check("retain_busy", 32'(busy1), 32'h0);
    check("retain_q_a", 32'(q_a1), 32'hAAAA);

`ifdef MEMORAM_DP_PARITY_EN
    perr_inject = 1'b1;
    op(1, 9, 16'h0001, 0, 0, 0);
    perr_inject = 1'b0;
    op(0, 9, 0, 1, 9, 1);
    check("par_q_a", 32'(q_a0), 32'h0001);
    check("par_inj_a", 32'(perr_a0), 32'h1);
    check("par_inj_b", 32'(perr_b0), 32'h1);
    op(1, 9, 16'h0001, 0, 0, 0);
    op(0, 9, 0, 1, 0, 0);
    check("par_clean_a", 32'(perr_a0), 32'h0);
`endif

    // Reset mid-clear restarts the full sequence; writes during busy are dropped.
    reset0 = 1'b1;
    op(0, 0, 0, 0, 0, 0);
    reset0 = 1'b0;
    for (int k = 0; k < 30; k++) op(1, 3, 16'hBEEF, 1, 3, 1);
    reset0 = 1'b1;
    op(1, 3, 16'hBEEF, 1, 3, 1);
    reset0 = 1'b0;
    busy_cycles = busy0 ? 1 : 0;
    for (int n = 0; n < 200 && busy0; n++) begin
      op(1, 3, 16'hBEEF, 1, 3, 1);
      check("busy_q_a_zero", 32'(q_a0), 32'h0);
      if (busy0) busy_cycles++;
    end
    check("busy_len_restart", 32'(busy_cycles), 32'd64);
    op(0, 3, 0, 1, 3, 1);
    check("beef_dropped_a", 32'(q_a0), 32'h0);
    check("beef_dropped_b", 32'(q_b0), 32'h0);

    // Randomized traffic with address clustering to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      logic [ADDR_W-1:0] aa, ab;
      aa = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom_range(0, DEPTH - 1));
      ab = ($urandom_range(0, 2) == 0) ? aa : ADDR_W'($urandom_range(0, 3));
      reset0 = ($urandom_range(0, 499) == 0);
      reset1 = ($urandom_range(0, 499) == 0);
      perr_inject = ($urandom_range(0, 7) == 0);
      op(1'($urandom_range(0, 1)), aa, DATA_W'($urandom),
         ($urandom_range(0, 3) != 0), ab, ($urandom_range(0, 3) != 0));
    end
    reset0 = 1'b0; reset1 = 1'b0; perr_inject = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
